mips_prog_loader: RTL and testbench
===================================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target memory (1024 words).
REQ-002 SHALL have port clk1  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-005 SHALL have port in_data  input  8  stream byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte.
REQ-008 SHALL have port mem_we  output  1  memory write strobe, one cycle per word.
REQ-009 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-010 SHALL have port mem_wdata  output  32  memory write data.
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port err  output  1  load failed.
REQ-014 SHALL have port cpu_run  output  1  releases the downstream pipeline from halt; equals done.

Function
REQ-015 SHALL transfer a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL use states IDLE, HDR_ADDR, HDR_CNT, DATA, CHK, DONE, ERR.
REQ-017 SHALL assert in_ready only in HDR_ADDR, HDR_CNT, DATA and CHK.
REQ-018 SHALL assemble every 4 accepted bytes into one word, big-endian, with the first byte in bits 31:24.
REQ-019 SHALL move from IDLE, DONE or ERR to HDR_ADDR on start=1; SHALL ignore start in every other state.
REQ-020 SHALL, in HDR_ADDR, take the 1st word as the base address (low ADDR_W bits) and then go to HDR_CNT.
REQ-021 SHALL, in HDR_CNT, take the 2nd word as a 32-bit word count N; N=0 goes straight to CHK (macro on) or DONE (macro off), otherwise to DATA.
REQ-022 SHALL, in DATA, pulse mem_we for exactly one cycle in the cycle after each word's 4th byte is accepted, with mem_addr = base + word index.
REQ-023 SHALL wrap mem_addr modulo 2^ADDR_W.
REQ-024 SHALL keep in_ready high during a write cycle: no stall, and back-to-back bytes every cycle are sustained.
REQ-025 SHALL leave DATA after the N-th word, going to CHK (macro on) or DONE (macro off).
REQ-026 SHALL tolerate gaps in in_valid: partial-word state is held, with no timeout.
REQ-027 SHALL drive busy=1 in HDR_ADDR, HDR_CNT, DATA and CHK; done=1 only in DONE; err=1 only in ERR.
REQ-028 SHALL hold mem_we=0 in every state except the write cycle.
REQ-029 SHALL, on a start from DONE or ERR, clear done, err and cpu_run in the next cycle.

Reset
REQ-030 SHALL, on rst=1 at a clk1 edge, enter IDLE and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_run=0.
REQ-031 SHALL, on reset mid-load, discard the partial word, byte counter, word counter and checksum; no write is issued after reset.
REQ-032 SHALL give rst priority over start and over byte acceptance in the same cycle.

Configuration
REQ-033 SHALL compile the checksum feature in only when macro MIPS_LOADER_CHECKSUM_EN is defined.
REQ-034 SHALL, with the macro defined, keep a running 8-bit XOR of all header and payload bytes.
REQ-035 SHALL, with the macro defined, accept one trailing byte in CHK; if it equals the XOR go to DONE, else ERR.
REQ-036 SHALL, without the macro, have no CHK state and no XOR logic; err is tied 0.

Verification
REQ-037 SHALL cover: header 00000000/00000008, then payload 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000 -> 8 writes to addr 0..7 with matching data, then done=1 and cpu_run=1.
REQ-038 SHALL cover: header base 0x3FF, N=2, payload 11111111, 22222222 -> writes addr 0x3FF=11111111 then addr 0x000=22222222.
REQ-039 SHALL cover: N=0 -> no mem_we; DONE follows the header (macro off) or the checksum byte (macro on).
REQ-040 SHALL cover (macro on): a correct XOR byte -> done=1; a corrupted byte (XOR^0x01) -> err=1 and cpu_run=0; a following start -> a fresh load succeeds.
REQ-041 SHALL cover: rst after 2 payload bytes, then a full reload -> no spurious write, and results identical to REQ-037.
REQ-042 SHALL cover: random 0-3 cycle in_valid gaps during the REQ-037 stream, plus start pulsed while busy -> identical writes, with start ignored.

Source files
------------

// File: rtl/mips_prog_loader.sv
// -----------------------------------------------------------------------------
// mips_prog_loader
//   Streams a program image from a byte interface into a word-addressed
//   instruction memory, then releases the CPU from halt.
//
//   Stream format (bytes, big-endian words):
//     word 0 : base word address (low ADDR_W bits used)
//     word 1 : payload word count N (32 bits)
//     word 2.. N+1 : payload, written to base+0 .. base+N-1 (mod 2^ADDR_W)
//     [trailing byte] : XOR of every header and payload byte
//                       (only when MIPS_LOADER_CHECKSUM_EN is defined)
//
//   Optional feature macro: MIPS_LOADER_CHECKSUM_EN
//     defined   -> CHK state and running XOR compiled in; a bad checksum
//                  ends in ERR.
//     undefined -> no CHK state, no XOR logic, err tied low.
//
//   Ports
//     clk1       in   system clock, all state on its rising edge
//     rst        in   synchronous active-high reset
//     start      in   begin a load (honoured only in IDLE/DONE/ERR)
//     in_data    in   stream byte
//     in_valid   in   in_data valid
//     in_ready   out  loader can take a byte this cycle
//     mem_we     out  one-cycle write strobe per payload word
//     mem_addr   out  write word address
//     mem_wdata  out  write data
//     busy       out  load in progress
//     done       out  load finished successfully
//     err        out  load failed (checksum mismatch)
//     cpu_run    out  pipeline release, identical to done
// -----------------------------------------------------------------------------
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_run
);

`ifdef MIPS_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_CNT  = 3'd2,
    DATA     = 3'd3,
    CHK      = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;
  // Where the FSM goes once the last payload word (or an empty header) is in.
  localparam state_t LOAD_END = CHK;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_CNT  = 3'd2,
    DATA     = 3'd3,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;
  localparam state_t LOAD_END = DONE;
`endif

  state_t state, nxt;

  logic [1:0]        bcnt;      // byte position inside the current word
  logic [23:0]       shreg;     // first three bytes of the current word
  logic [ADDR_W-1:0] base;
  logic [31:0]       nwords;
  logic [31:0]       widx;      // payload words already written

  logic        acc;
  logic        collect;
  logic        word_end;
  logic        last_word;
  logic        restart;
  logic [31:0] word;

`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [7:0] xsum;
`endif

  assign acc       = in_valid & in_ready;
  // States whose bytes are assembled into words.
  assign collect   = (state == HDR_ADDR) || (state == HDR_CNT) || (state == DATA);
  assign word_end  = acc & collect & (bcnt == 2'd3);
  // Completed word is visible combinationally in the cycle of its 4th byte.
  assign word      = {shreg, in_data};
  // nwords is never 0 while in DATA, so the subtraction cannot underflow there.
  assign last_word = (widx == nwords - 32'd1);
  assign restart   = start & ((state == IDLE) || (state == DONE) || (state == ERR));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) nxt = HDR_ADDR;
      end
      HDR_ADDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_end) nxt = HDR_CNT;
      end
      HDR_CNT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_end) nxt = (word == 32'd0) ? LOAD_END : DATA;
      end
      DATA: begin
        // in_ready stays high through the write cycle: the write is a
        // registered side effect, so the byte stream never stalls.
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_end && last_word) nxt = LOAD_END;
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (acc) nxt = (in_data == xsum) ? DONE : ERR;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  assign done    = (state == DONE);
  assign cpu_run = done;
`ifdef MIPS_LOADER_CHECKSUM_EN
  assign err     = (state == ERR);
`else
  assign err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Word assembly, header capture and memory write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      bcnt      <= 2'd0;
      shreg     <= 24'd0;
      base      <= '0;
      nwords    <= 32'd0;
      widx      <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        bcnt <= 2'd0;
        widx <= 32'd0;
      end
      // Partial word is simply held across in_valid gaps.
      if (acc && collect) begin
        bcnt  <= bcnt + 2'd1;
        shreg <= {shreg[15:0], in_data};
      end
      if (word_end) begin
        case (state)
          HDR_ADDR: base   <= word[ADDR_W-1:0];
          HDR_CNT:  nwords <= word;
          DATA: begin
            mem_we    <= 1'b1;
            // ADDR_W-bit add wraps naturally modulo 2^ADDR_W.
            mem_addr  <= base + widx[ADDR_W-1:0];
            mem_wdata <= word;
            widx      <= widx + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MIPS_LOADER_CHECKSUM_EN
  // Running XOR over header and payload bytes; the trailing check byte
  // itself is not folded in.
  always_ff @(posedge clk1) begin
    if (rst)               xsum <= 8'd0;
    else if (restart)      xsum <= 8'd0;
    else if (acc && collect) xsum <= xsum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;
  localparam int AW = 10;
`ifdef MIPS_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk1 = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, busy, done, err, cpu_run;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  mips_prog_loader #(.ADDR_W(AW)) dut (
    .clk1(clk1), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err), .cpu_run(cpu_run)
  );

  always #5 clk1 = ~clk1;

  int total  = 0;
  int passed = 0;

  logic [31:0]   pay[$];
  logic [31:0]   prog[$];
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  // Write monitor, sampled mid-cycle.
  always @(negedge clk1)
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax, input bit sb);
    int g, guard;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    repeat (g) @(negedge clk1);
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    start    = sb;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk1);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk1); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Reference model: the stream is header(base,N) + payload (+ XOR byte);
  // expected writes are payload[i] at (base+i) mod 2^AW.
  task automatic run_load(input string name, input logic [31:0] base, input int gmax,
                          input bit sbusy, input bit corrupt);
    logic [7:0]  bq[$];
    logic [31:0] ws[$];
    logic [7:0]  x;
    bit          bad;
    int          n;
    wa.delete(); wd.delete();
    @(negedge clk1); start = 1'b1;
    @(posedge clk1); #1; start = 1'b0;
    check({name, "_start_status"}, 64'({busy, done, err, cpu_run, in_ready}), 64'(5'b10001));
    ws = {base, 32'(pay.size())};
    foreach (pay[i]) ws.push_back(pay[i]);
    foreach (ws[i]) for (int k = 3; k >= 0; k--) bq.push_back(ws[i][k*8 +: 8]);
    x = 8'd0;
    foreach (bq[i]) begin
      x ^= bq[i];
      send_byte(bq[i], gmax, sbusy && (i == 9 || i == 15));
    end
`ifdef MIPS_LOADER_CHECKSUM_EN
    send_byte(x ^ {7'd0, corrupt}, gmax, 1'b0);
`endif
    repeat (2) @(negedge clk1);
    n = pay.size();
    check({name, "_nwrites"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check($sformatf("%s_addr[%0d]", name, i), 64'(wa[i]),
            64'((longint'(base) + i) % (longint'(1) << AW)));
      check($sformatf("%s_data[%0d]", name, i), 64'(wd[i]), 64'(pay[i]));
    end
    bad = corrupt & CSUM;
    check({name, "_end_status"}, 64'({busy, done, err, cpu_run, in_ready, mem_we}),
          bad ? 64'(6'b001000) : 64'(6'b010100));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    repeat (3) @(posedge clk1); #1;
    check("reset_ctrl", 64'({in_ready, mem_we, busy, done, err, cpu_run}), 64'(0));
    check("reset_addr", 64'(mem_addr), 64'(0));
    check("reset_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;

    // Reference program at base 0.
    pay = prog;
    run_load("prog", 32'h0, 0, 1'b0, 1'b0);

    // Address wrap at top of memory.
    pay = '{32'h11111111, 32'h22222222};
    run_load("wrap", 32'h3FF, 0, 1'b0, 1'b0);

    // Empty payload.
    pay.delete();
    run_load("empty", 32'h5, 0, 1'b0, 1'b0);

`ifdef MIPS_LOADER_CHECKSUM_EN
    pay = prog;
    run_load("badsum", 32'h0, 0, 1'b0, 1'b1);
    run_load("after_err", 32'h0, 0, 1'b0, 1'b0);
`endif

    // Reset in the middle of the payload, then a full reload.
    wa.delete(); wd.delete();
    @(negedge clk1); start = 1'b1;
    @(posedge clk1); #1; start = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'h00, 0, 1'b0);
    send_byte(8'h08, 0, 1'b0);
    send_byte(8'h28, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    @(negedge clk1); rst = 1'b1;
    @(posedge clk1); #1;
    check("midrst_ctrl", 64'({in_ready, mem_we, busy, done, err, cpu_run}), 64'(0));
    check("midrst_addr_data", 64'({mem_addr, mem_wdata}), 64'(0));
    @(negedge clk1); rst = 1'b0;
    repeat (3) @(negedge clk1);
    check("midrst_nowrite", 64'(wa.size()), 64'(0));
    pay = prog;
    run_load("reload", 32'h0, 0, 1'b0, 1'b0);

    // Random in_valid gaps plus start pulses while busy.
    run_load("gaps", 32'h0, 3, 1'b1, 1'b0);

    // Random images.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = int'($urandom_range(6, 1));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back($urandom);
      run_load($sformatf("rnd%0d", t), $urandom, 2, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
